// File: rtl/complex_mult_arb.sv
// Round-robin arbiter sharing one external pipelined complex_mult between two requesters.
// Tracks result ownership with a tag pipeline aligned to the multiplier latency.
module complex_mult_arb #(
    parameter int W        = 8,
    parameter int MULT_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a1,
    input  logic [W-1:0] req0_b1,
    input  logic [W-1:0] req0_a2,
    input  logic [W-1:0] req0_b2,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a1,
    input  logic [W-1:0] req1_b1,
    input  logic [W-1:0] req1_a2,
    input  logic [W-1:0] req1_b2,
    output logic [W-1:0] a1,
    output logic [W-1:0] b1,
    output logic [W-1:0] a2,
    output logic [W-1:0] b2,
    input  logic [W-1:0] res_re,
    input  logic [W-1:0] res_im,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_re,
    output logic [W-1:0] rsp0_im,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_re,
    output logic [W-1:0] rsp1_im,
    output logic         busy
);

    // Entry 0 sits beside the operand register; entries 1..MULT_LAT track the multiplier stages.
    localparam int D = MULT_LAT + 1;

    logic         last_q, last_d;
    logic         grant, gid;
    logic [W-1:0] a1_q, b1_q, a2_q, b2_q;
    logic [W-1:0] a1_d, b1_d, a2_d, b2_d;
    logic [D-1:0] tvld_q, tid_q;
    logic         rsp0_valid_q, rsp1_valid_q;
    logic [W-1:0] rsp0_re_q, rsp0_im_q, rsp1_re_q, rsp1_im_q;
    logic         tag_out_vld, tag_out_id;

    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last_q);
        req1_ready = req1_valid && (!req0_valid || !last_q);
        grant      = req0_ready || req1_ready;
        gid        = req1_ready;
        last_d     = grant ? gid : last_q;
        a1_d       = '0;
        b1_d       = '0;
        a2_d       = '0;
        b2_d       = '0;
        if (req0_ready) begin
            a1_d = req0_a1;
            b1_d = req0_b1;
            a2_d = req0_a2;
            b2_d = req0_b2;
        end else if (req1_ready) begin
            a1_d = req1_a1;
            b1_d = req1_b1;
            a2_d = req1_a2;
            b2_d = req1_b2;
        end
    end

    assign tag_out_vld = tvld_q[D-1];
    assign tag_out_id  = tid_q[D-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            a1_q   <= '0;
            b1_q   <= '0;
            a2_q   <= '0;
            b2_q   <= '0;
            tvld_q <= '0;
            tid_q  <= '0;
        end else begin
            last_q <= last_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            a2_q   <= a2_d;
            b2_q   <= b2_d;
            tvld_q <= {tvld_q[D-2:0], grant};
            tid_q  <= {tid_q[D-2:0], gid};
        end
    end

    // Results are captured at the edge where the owning tag leaves the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_re_q    <= '0;
            rsp0_im_q    <= '0;
            rsp1_re_q    <= '0;
            rsp1_im_q    <= '0;
        end else begin
            rsp0_valid_q <= tag_out_vld && !tag_out_id;
            rsp1_valid_q <= tag_out_vld && tag_out_id;
            if (tag_out_vld && !tag_out_id) begin
                rsp0_re_q <= res_re;
                rsp0_im_q <= res_im;
            end
            if (tag_out_vld && tag_out_id) begin
                rsp1_re_q <= res_re;
                rsp1_im_q <= res_im;
            end
        end
    end

    assign a1         = a1_q;
    assign b1         = b1_q;
    assign a2         = a2_q;
    assign b2         = b2_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_re    = rsp0_re_q;
    assign rsp0_im    = rsp0_im_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_re    = rsp1_re_q;
    assign rsp1_im    = rsp1_im_q;
    assign busy       = |tvld_q;

endmodule

// File: tb/tb_complex_mult_arb.sv
// Bench for complex_mult_arb: behavioural complex_mult plus a scoreboard-based arbitration model.
module tb_complex_mult_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic v0, v1;
    logic [3:0][7:0] o0, o1;   // {b2, a2, b1, a1}
    logic req0_ready, req1_ready;
    logic [7:0] a1, b1, a2, b2, res_re, res_im;
    logic rsp0_valid, rsp1_valid, busy;
    logic [7:0] rsp0_re, rsp0_im, rsp1_re, rsp1_im;

    always #5 clk = ~clk;

    complex_mult_arb #(.W(8), .MULT_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(req0_ready),
        .req0_a1(o0[0]), .req0_b1(o0[1]), .req0_a2(o0[2]), .req0_b2(o0[3]),
        .req1_valid(v1), .req1_ready(req1_ready),
        .req1_a1(o1[0]), .req1_b1(o1[1]), .req1_a2(o1[2]), .req1_b2(o1[3]),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2),
        .res_re(res_re), .res_im(res_im),
        .rsp0_valid(rsp0_valid), .rsp0_re(rsp0_re), .rsp0_im(rsp0_im),
        .rsp1_valid(rsp1_valid), .rsp1_re(rsp1_re), .rsp1_im(rsp1_im),
        .busy(busy)
    );

    function automatic logic [7:0] cre(logic [3:0][7:0] o);
        logic [31:0] r;
        r = 32'($signed(o[0]) * $signed(o[2]) - $signed(o[1]) * $signed(o[3]));
        return r[7:0];
    endfunction

    function automatic logic [7:0] cim(logic [3:0][7:0] o);
        logic [31:0] r;
        r = 32'($signed(o[0]) * $signed(o[3]) + $signed(o[1]) * $signed(o[2]));
        return r[7:0];
    endfunction

    // External complex_mult with two register stages, results truncated to 8 bits.
    logic [7:0] m1_re, m1_im, m2_re, m2_im;
    always @(posedge clk) begin
        m1_re <= cre({b2, a2, b1, a1});
        m1_im <= cim({b2, a2, b1, a1});
        m2_re <= m1_re;
        m2_im <= m1_im;
    end
    assign res_re = m2_re;
    assign res_im = m2_im;

    typedef struct {
        bit         id;
        logic [7:0] re;
        logic [7:0] im;
        int         due;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              errs = 0;
    int              checks = 0;
    bit              mlast = 1'b1;
    logic [3:0][7:0] eop = '0;
    bit              g0, g1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic step();
        bit   e0, e1, ebusy, er0, er1;
        exp_t ent;
        #1;
        chk("operands", {a1, b1, a2, b2}, {eop[0], eop[1], eop[2], eop[3]});
        e0 = v0 && (!v1 || mlast);
        e1 = v1 && (!v0 || !mlast);
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        ebusy = 1'b0;
        foreach (sb[i]) if (sb[i].due > cyc) ebusy = 1'b1;
        chk("busy", 32'(busy), 32'(ebusy));
        er0 = 1'b0;
        er1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ent = sb.pop_front();
            if (ent.id == 1'b0) begin
                er0 = 1'b1;
                chk("rsp0_data", {rsp0_re, rsp0_im}, {ent.re, ent.im});
            end else begin
                er1 = 1'b1;
                chk("rsp1_data", {rsp1_re, rsp1_im}, {ent.re, ent.im});
            end
        end
        chk("rsp0_valid", 32'(rsp0_valid), 32'(er0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(er1));
        g0 = e0;
        g1 = e1;
        if (e0 || e1) begin
            eop   = e0 ? o0 : o1;
            sb.push_back('{id: e1, re: cre(eop), im: cim(eop), due: cyc + 4});
            mlast = e1;
        end else begin
            eop = '0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        v0 = 1'b0;
        v1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        v0 = 1'b0;
        v1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ops", {a1, b1, a2, b2}, 32'h0);
        chk("rst_rsp0", {rsp0_valid, rsp0_re, rsp0_im}, 32'h0);
        chk("rst_rsp1", {rsp1_valid, rsp1_re, rsp1_im}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        sb.delete();
        mlast = 1'b1;
        eop   = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit p0, p1;
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        o0 = '0;
        o1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("init_ops", {a1, b1, a2, b2}, 32'h0);
        chk("init_rsp", {rsp0_valid, rsp1_valid, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single request: (-2+4j)*(3-7j) = 22+26j
        o0 = {8'hF9, 8'd3, 8'd4, 8'hFE};
        v0 = 1'b1;
        step();
        idle(6);
        chk("single_result", {rsp0_re, rsp0_im}, {8'd22, 8'd26});
        chk("single_rsp1_untouched", {rsp1_re, rsp1_im}, 32'h0);

        // Contention from a fresh reset: grants alternate starting with requester 0.
        do_reset();
        o0 = {8'd0, 8'd2, 8'd1, 8'd1};
        o1 = {8'd1, 8'd0, 8'd1, 8'd0};
        v0 = 1'b1;
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("contend_alt", {31'd0, g1}, 32'(i % 2));
        end
        idle(6);
        chk("contend_r0", {rsp0_re, rsp0_im}, {8'd2, 8'd2});
        chk("contend_r1", {rsp1_re, rsp1_im}, {8'hFF, 8'd0});

        // Back-to-back on requester 1 with distinct operands.
        for (int i = 0; i < 5; i++) begin
            o1 = {8'(i), 8'(3 - i), 8'(2 * i + 1), 8'(5 + i)};
            v1 = 1'b1;
            step();
            chk("b2b_grant", 32'(g1), 32'h1);
        end
        idle(6);

        // Pointer hold: three solo grants to requester 0, then requester 1 wins the contest.
        o0 = {8'd9, 8'd8, 8'd7, 8'd6};
        v0 = 1'b1;
        repeat (3) step();
        v1 = 1'b1;
        #1;
        chk("ptr_hold", {req0_ready, req1_ready}, 32'h1);
        step();
        idle(6);

        // Reset with two operations in flight; they must never respond.
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        v1 = 1'b1;
        step();
        do_reset();
        idle(8);
        v0 = 1'b1;
        v1 = 1'b1;
        #1;
        chk("post_rst_contest", {req0_ready, req1_ready}, 32'h2);
        step();
        idle(6);

        // Wrap pass-through: (127+127j)*127 truncates to 1+1j.
        o0 = {8'd0, 8'd127, 8'd127, 8'd127};
        v0 = 1'b1;
        step();
        idle(6);
        chk("wrap_result", {rsp0_re, rsp0_im}, {8'd1, 8'd1});

        // Randomized traffic; each requester holds its operands until transfer.
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1;
                o0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1;
                o1 = $urandom;
            end
            v0 = p0;
            v1 = p1;
            step();
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        idle(6);
        chk("drain_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
